// File: rtl/dut_initiator.sv
// dut_initiator: turns one sequencer command into exactly one write or read
// method call on the target, with a bounded wait for the method to become
// ready, and returns a single response.
//
// Ports
//   CLK, RST_N                 clock; synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready only in IDLE)
//   cmd_write/addr/data        command payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready        response handshake
//   rsp_data/rsp_err           read data (0 for writes/errors), timeout flag
//   write_address/data/en/rdy  write method towards the target
//   read_address/en/data/rdy   read method towards the target
//
// Parameter TIMEOUT (1..255): wait cycles allowed before aborting.
module dut_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  input  logic       cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_data,
  output logic       rsp_err,
  output logic [2:0] write_address,
  output logic       write_data,
  output logic       write_en,
  input  logic       write_rdy,
  output logic [2:0] read_address,
  output logic       read_en,
  input  logic       read_data,
  input  logic       read_rdy
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                rsp_valid_q;
  logic                rsp_data_q;
  logic                rsp_err_q;
  logic [ADDR_W-1:0]   write_address_q;
  logic                write_data_q;
  logic [ADDR_W-1:0]   read_address_q;
  logic                timeout_c;

  // Method enables follow rdy combinationally so a call fires the same cycle
  // the target is ready; they can never be high while rdy is low.
  assign write_en  = (state_q == S_WR) && write_rdy;
  assign read_en   = (state_q == S_RD) && read_rdy;

  // Held low while reset is asserted so no command is taken during reset.
  assign cmd_ready = (state_q == S_IDLE) && !RST_N;

  // Wait counter: the cycle that would bring it to TIMEOUT without a fire
  // is the last one allowed.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    timeout_c = (cnt_d == TIMEOUT_C);
  end

  // Transaction FSM with registered payload and response fields.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 1'b0;
      rsp_err_q       <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= 1'b0;
      read_address_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            cnt_q <= '0;
            if (cmd_write) begin
              write_address_q <= cmd_addr;
              write_data_q    <= cmd_data;
              state_q         <= S_WR;
            end else begin
              read_address_q  <= cmd_addr;
              state_q         <= S_RD;
            end
          end
        end
        S_WR: begin
          if (write_en) begin
            state_q     <= S_RSP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            if (timeout_c) begin
              state_q     <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (read_en) begin
            state_q     <= S_RSP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= read_data;
          end else begin
            cnt_q <= cnt_d;
            if (timeout_c) begin
              state_q     <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 1'b0;
            end
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign read_address  = read_address_q;

endmodule

// File: doc/dut_initiator.md
DUT_INITIATOR -- requirements
Module: dut_initiator

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum number of cycles to wait for a method ready before aborting; legal range 1..255.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset; synchronous, active-high (asserted = 1); port name kept per codebase convention.
REQ-004 cmd_valid  input  1  command request from the sequencer side.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready on a rising edge.
REQ-006 cmd_write  input  1  1 = write transaction, 0 = read transaction.
REQ-007 cmd_addr  input  3  target method address.
REQ-008 cmd_data  input  1  write data; ignored for reads.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-011 rsp_data  output  1  read data captured on method fire; 0 for writes and for errors.
REQ-012 rsp_err  output  1  1 = transaction aborted on timeout.
REQ-013 write_address  output  3  write method address to the target.
REQ-014 write_data  output  1  write method data.
REQ-015 write_en  output  1  write method enable.
REQ-016 write_rdy  input  1  write method ready from the target.
REQ-017 read_address  output  3  read method address.
REQ-018 read_en  output  1  read method enable.
REQ-019 read_data  input  1  read method result; valid in the cycle read_en fires.
REQ-020 read_rdy  input  1  read method ready from the target.

Function
REQ-021 FSM states: IDLE, WR, RD, RSP.
REQ-022 cmd_ready SHALL be 1 only in IDLE; on accept, go to WR if cmd_write=1, else to RD; register cmd_addr/cmd_data into write_address/write_data or read_address.
REQ-023 write_address, write_data and read_address SHALL hold their values until the next accepted command of the same type.
REQ-024 write_en SHALL be combinational (state==WR) && write_rdy; read_en SHALL be (state==RD) && read_rdy; no enable is ever driven while its rdy is 0.
REQ-025 A method fires in the cycle its en is 1; exactly one fire per command; on fire go to RSP with rsp_err=0.
REQ-026 On a read fire, rsp_data SHALL capture read_data from that same cycle.
REQ-027 Wait counter (8 bits) SHALL clear on accept and increment each WR/RD cycle without a fire.
REQ-028 When the counter reaches TIMEOUT without a fire, go to RSP with rsp_err=1 and rsp_data=0, with no enable asserted in that cycle.
REQ-029 Best-case latency: accept at edge N -> en high during cycle N+1 -> rsp_valid high from edge N+2.
REQ-030 rsp_valid=1 only in RSP; rsp_data/rsp_err SHALL be stable while rsp_valid && !rsp_ready.
REQ-031 On rsp_ready in RSP, return to IDLE; cmd_ready rises the following cycle; there is no back-to-back overlap.
REQ-032 If rdy rises in the same cycle the counter hits TIMEOUT, the fire wins (rsp_err=0).
REQ-033 cmd_valid in any state other than IDLE SHALL be ignored.

Reset
REQ-034 While RST_N=1 at an edge: state=IDLE, counter=0, rsp_valid=0, rsp_data=0, rsp_err=0, write_address=0, write_data=0, read_address=0; cmd_ready=0 during reset.
REQ-035 Reset mid-transaction SHALL drop the transaction; write_en/read_en are 0 the cycle after the reset edge; no response is produced.

Verification
REQ-036 Write addr=4 data=1, write_rdy=1 -> write_en=1 for exactly one cycle with write_address=4, write_data=1; rsp_valid two edges after accept, rsp_err=0.
REQ-037 Read addr=3 with read_rdy=1 and read_data=1 -> read_en=1 for one cycle; rsp_data=1, rsp_err=0.
REQ-038 Write with write_rdy held 0 for 5 cycles, then 1 (TIMEOUT=16) -> write_en only in the first cycle rdy=1; rsp_err=0.
REQ-039 Read with read_rdy never 1 (TIMEOUT=16) -> read_en stays 0; rsp_valid after 16 wait cycles with rsp_err=1 and rsp_data=0.
REQ-040 Hold rsp_ready=0 for 4 cycles in RSP -> rsp fields stable and cmd_ready=0; a new cmd_valid is not accepted until one cycle after rsp_ready.
REQ-041 Assert RST_N=1 while in WR with write_rdy=0 -> next cycle IDLE with all outputs at their reset values, no response, and no write_en.
